// File: rtl/mem_io_ctrl_pkg.sv
// Shared constants and types for the CPU memory/IO responder.
package mem_io_ctrl_pkg;

    localparam int ByteLen = 8;
    localparam int AddrLen = 32;

    localparam logic [1:0]  IO_SEL  = 2'b11;
    localparam logic [17:0] IO_UART = 18'h30000;
    localparam logic [17:0] IO_CLK  = 18'h30004;

    typedef enum logic {
        SRC_RAM,
        SRC_IO
    } rd_src_e;

endpackage

// File: rtl/mem_io_ctrl_byte_fifo.sv
// Circular byte FIFO with occupancy count; head byte is combinational.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PtrW = $clog2(DEPTH);
    localparam int CntW = PtrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW-1:0]  wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CntW'(DEPTH));
    assign head_data = mem[rd_ptr];
    assign do_pop    = pop && !empty;
    // A simultaneous pop frees the slot, so a push is accepted even when full.
    assign do_push   = push && (!full || do_pop);

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_ctrl.sv
// Responder for the CPU byte bus: 128 KB RAM plus UART, cycle counter and stop flag I/O.
module mem_io_ctrl
    import mem_io_ctrl_pkg::*;
#(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [AddrLen-1:0]   cpu_mem_a,
    input  logic                 cpu_mem_wr,
    input  logic [ByteLen-1:0]   cpu_mem_dout,
    output logic [ByteLen-1:0]   cpu_mem_din,
    output logic                 rdy_out,
    output logic [ByteLen-1:0]   tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [ByteLen-1:0]   rx_data,
    input  logic                 rx_valid,
    output logic                 rx_pop,
    output logic                 program_finished,
    output logic                 tx_overflow
);

    localparam int CntW = $clog2(TX_DEPTH) + 1;

    logic [ByteLen-1:0]    ram [2**RAM_ADDR_W];
    logic [ByteLen-1:0]    ram_q;
    logic [RAM_ADDR_W-1:0] ram_a;
    logic [17:0]           io_a;
    logic                  is_io;
    logic                  is_uart;
    logic                  is_clk_rd;
    logic                  is_clk_wr;
    logic [AddrLen-19:0]   unused_a_hi;

    logic [31:0]           counter;
    logic [31:0]           snapshot;
    logic [ByteLen-1:0]    io_rd_byte;
    logic [ByteLen-1:0]    io_byte;
    logic                  rd_pend;
    rd_src_e               rd_src;

    logic                  fifo_push;
    logic [ByteLen-1:0]    fifo_push_data;
    logic                  fifo_pop;
    logic [CntW-1:0]       fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push_ok;
    logic                  pop_ok;
    logic [CntW-1:0]       next_count;

    assign ram_a       = cpu_mem_a[RAM_ADDR_W-1:0];
    assign io_a        = cpu_mem_a[17:0];
    assign unused_a_hi = cpu_mem_a[AddrLen-1:18];
    assign is_io       = (cpu_mem_a[17:16] == IO_SEL);
    assign is_uart     = is_io && (io_a == IO_UART);
    assign is_clk_rd   = is_io && (io_a[17:2] == IO_CLK[17:2]);
    assign is_clk_wr   = is_io && (io_a == IO_CLK);

    assign fifo_push      = cpu_mem_wr && ((is_uart && cpu_mem_dout != '0) || is_clk_wr);
    assign fifo_push_data = is_clk_wr ? '0 : cpu_mem_dout;
    assign fifo_pop       = tx_valid && tx_ready;
    assign tx_valid       = !fifo_empty;

    byte_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (ByteLen)
    ) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head_data (tx_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pop_ok  = fifo_pop && !fifo_empty;
    assign push_ok = fifo_push && (!fifo_full || pop_ok);

    always_comb begin
        next_count = fifo_count;
        if (push_ok) begin
            next_count = next_count + CntW'(1);
        end
        if (pop_ok) begin
            next_count = next_count - CntW'(1);
        end
    end

    // Reading 0x30004 returns the live counter byte; 0x30005..7 come from the snapshot it latched.
    always_comb begin
        io_rd_byte = '0;
        if (is_uart) begin
            io_rd_byte = rx_valid ? rx_data : '0;
        end else if (is_clk_rd) begin
            case (io_a[1:0])
                2'd0:    io_rd_byte = counter[7:0];
                2'd1:    io_rd_byte = snapshot[15:8];
                2'd2:    io_rd_byte = snapshot[23:16];
                default: io_rd_byte = snapshot[31:24];
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!is_io) begin
            if (cpu_mem_wr) begin
                ram[ram_a] <= cpu_mem_dout;
            end else begin
                ram_q <= ram[ram_a];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cpu_mem_din      <= '0;
            rdy_out          <= 1'b1;
            rx_pop           <= 1'b0;
            counter          <= '0;
            snapshot         <= '0;
            program_finished <= 1'b0;
            tx_overflow      <= 1'b0;
            rd_pend          <= 1'b0;
            rd_src           <= SRC_RAM;
            io_byte          <= '0;
        end else begin
            counter <= counter + 32'd1;
            rdy_out <= (next_count <= CntW'(TX_DEPTH - 2));
            rx_pop  <= !cpu_mem_wr && is_uart && rx_valid;
            rd_pend <= !cpu_mem_wr;
            rd_src  <= is_io ? SRC_IO : SRC_RAM;
            io_byte <= io_rd_byte;
            if (cpu_mem_wr && is_clk_wr) begin
                program_finished <= 1'b1;
            end
            if (fifo_push && !push_ok) begin
                tx_overflow <= 1'b1;
            end
            if (!cpu_mem_wr && is_clk_rd && io_a[1:0] == 2'd0) begin
                snapshot <= counter;
            end
            if (rd_pend) begin
                cpu_mem_din <= (rd_src == SRC_RAM) ? ram_q : io_byte;
            end
        end
    end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed self-checking bench for mem_io_ctrl.
module tb_mem_io_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_mem_a;
    logic        cpu_mem_wr;
    logic [7:0]  cpu_mem_dout;
    logic [7:0]  cpu_mem_din;
    logic        rdy_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        program_finished;
    logic        tx_overflow;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ref_cnt = '0;
    int          pop_cnt = 0;
    logic [7:0]  tx_seen [$];

    localparam logic [31:0] IDLE_A = 32'h0003_0010;

    mem_io_ctrl #(
        .RAM_ADDR_W (17),
        .TX_DEPTH   (8)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .cpu_mem_a        (cpu_mem_a),
        .cpu_mem_wr       (cpu_mem_wr),
        .cpu_mem_dout     (cpu_mem_dout),
        .cpu_mem_din      (cpu_mem_din),
        .rdy_out          (rdy_out),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_pop           (rx_pop),
        .program_finished (program_finished),
        .tx_overflow      (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Expected cycle counter: zero at reset, +1 per non-reset edge.
    always @(posedge clk_in) ref_cnt <= rst_in ? 32'd0 : ref_cnt + 32'd1;

    always @(negedge clk_in) begin
        if (!rst_in && tx_valid && tx_ready) tx_seen.push_back(tx_data);
        if (!rst_in && rx_pop) pop_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d);
        cpu_mem_a    = a;
        cpu_mem_wr   = wr;
        cpu_mem_dout = d;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        cyc(IDLE_A, 1'b1, 8'h00);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [7:0] exp);
        cyc(a, 1'b0, 8'h00);
        idle();
        check(tag, {24'h0, cpu_mem_din}, {24'h0, exp});
    endtask

    initial begin
        logic [31:0] word;
        logic [31:0] exp_w;

        rst_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cpu_mem_a = IDLE_A; cpu_mem_wr = 1'b1; cpu_mem_dout = 8'h00;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_din",  {24'h0, cpu_mem_din}, 32'h0);
        check("rst_rdy",  {31'h0, rdy_out}, 32'h1);
        check("rst_txv",  {31'h0, tx_valid}, 32'h0);
        check("rst_pop",  {31'h0, rx_pop}, 32'h0);
        check("rst_pf",   {31'h0, program_finished}, 32'h0);
        check("rst_ovf",  {31'h0, tx_overflow}, 32'h0);
        rst_in = 1'b0;

        // RAM round trips, including the top address
        cyc(32'h0000_0010, 1'b1, 8'h5A);
        rd_chk("ram_10", 32'h0000_0010, 8'h5A);
        cyc(32'h0001_FFFF, 1'b1, 8'hA5);
        rd_chk("ram_1ffff", 32'h0001_FFFF, 8'hA5);
        cyc(32'h0000_0010, 1'b1, 8'h11);
        idle();
        check("din_hold_on_wr", {24'h0, cpu_mem_din}, 32'hA5);
        rd_chk("ram_10_new", 32'h0000_0010, 8'h11);

        // UART output, zero byte ignored
        tx_ready = 1'b1;
        tx_seen.delete();
        cyc(32'h0003_0000, 1'b1, 8'h41);
        cyc(32'h0003_0000, 1'b1, 8'h00);
        cyc(32'h0003_0000, 1'b1, 8'h42);
        repeat (4) idle();
        check("uart_n", tx_seen.size(), 32'd2);
        if (tx_seen.size() == 2) begin
            check("uart_b0", {24'h0, tx_seen[0]}, 32'h41);
            check("uart_b1", {24'h0, tx_seen[1]}, 32'h42);
        end
        check("uart_ovf", {31'h0, tx_overflow}, 32'h0);

        // Backpressure and overflow
        tx_ready = 1'b0;
        tx_seen.delete();
        for (int i = 1; i <= 9; i++) begin
            cyc(32'h0003_0000, 1'b1, 8'(i));
            if (i == 5) check("rdy_after5", {31'h0, rdy_out}, 32'h1);
            if (i == 7) check("rdy_after7", {31'h0, rdy_out}, 32'h0);
        end
        check("bp_ovf",  {31'h0, tx_overflow}, 32'h1);
        check("bp_head", {24'h0, tx_data}, 32'h01);
        tx_ready = 1'b1;
        repeat (12) idle();
        check("bp_n", tx_seen.size(), 32'd8);
        for (int i = 0; i < 8 && i < tx_seen.size(); i++)
            check("bp_order", {24'h0, tx_seen[i]}, 32'(i + 1));
        check("bp_rdy_back", {31'h0, rdy_out}, 32'h1);
        check("bp_empty", {31'h0, tx_valid}, 32'h0);

        // RX read with and without a pending byte
        rx_valid = 1'b1; rx_data = 8'h37;
        pop_cnt = 0;
        cyc(32'h0003_0000, 1'b0, 8'h00);
        check("rx_pop_pulse", {31'h0, rx_pop}, 32'h1);
        rx_valid = 1'b0; rx_data = 8'h00;
        idle();
        check("rx_data", {24'h0, cpu_mem_din}, 32'h37);
        check("rx_pop_end", {31'h0, rx_pop}, 32'h0);
        rd_chk("rx_empty", 32'h0003_0000, 8'h00);
        check("rx_pop_count", pop_cnt, 32'd1);
        rd_chk("unmapped_io", 32'h0003_0008, 8'h00);

        // Coherent clock read across a carry into byte 1
        for (int i = 0; i < 1000 && ref_cnt < 32'hFE; i++) idle();
        check("clk_wait", ref_cnt, 32'hFE);
        exp_w = ref_cnt;
        cyc(32'h0003_0004, 1'b0, 8'h00);
        cyc(32'h0003_0005, 1'b0, 8'h00);
        word[7:0] = cpu_mem_din;
        cyc(32'h0003_0006, 1'b0, 8'h00);
        word[15:8] = cpu_mem_din;
        cyc(32'h0003_0007, 1'b0, 8'h00);
        word[23:16] = cpu_mem_din;
        idle();
        word[31:24] = cpu_mem_din;
        check("clk_word", word, exp_w);

        // Stop write, then reset mid-drain
        tx_ready = 1'b0;
        cyc(32'h0003_0004, 1'b1, 8'hFF);
        check("stop_pf",   {31'h0, program_finished}, 32'h1);
        check("stop_txv",  {31'h0, tx_valid}, 32'h1);
        check("stop_txd",  {24'h0, tx_data}, 32'h00);
        cyc(32'h0003_0000, 1'b1, 8'h55);
        cyc(32'h0003_0000, 1'b1, 8'h56);
        tx_ready = 1'b1;
        idle();
        rst_in = 1'b1;
        idle();
        rst_in = 1'b0;
        check("rst2_txv", {31'h0, tx_valid}, 32'h0);
        check("rst2_pf",  {31'h0, program_finished}, 32'h0);
        check("rst2_rdy", {31'h0, rdy_out}, 32'h1);
        check("rst2_ovf", {31'h0, tx_overflow}, 32'h0);
        rd_chk("rst2_cnt0", 32'h0003_0004, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
